// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive datapaths.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        ODD   = 2'b01,
        EVEN  = 2'b10,
        STICK = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_t;

    // Per-frame settings, frozen when a character is popped.
    typedef struct packed {
        logic [3:0] dbits;
        parity_t    par;
        logic       stop2;
    } tx_cfg_t;

    localparam int MIN_DBITS = 5;

    function automatic logic [3:0] clamp_dbits(input logic [3:0] req, input logic [3:0] max_dbits);
        if (req < 4'(MIN_DBITS)) begin
            return 4'(MIN_DBITS);
        end else if (req > max_dbits) begin
            return max_dbits;
        end
        return req;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count.
// Latency: push visible on level/empty next cycle; read data is the head, combinational.
// Backpressure: push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed serialiser with parity, 1/2 stop bits and break.
// Latency: write to line falling edge is 2 cycles when idle; frames run back-to-back.
// Backpressure: wr_ready_o is low while the FIFO is full; writes then are dropped.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV_W  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [CLK_DIV_W-1:0]          cr_clk_div_i,
    input  logic [3:0]                    cr_dbits_i,
    input  logic [1:0]                    cr_p_i,
    input  logic                          cr_pstick_i,
    input  logic                          cr_s_i,
    input  logic                          cr_brk_i,
    input  logic                          wr_valid_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    output logic                          wr_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          uart_tx_o
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t            state_q, state_d;
    tx_cfg_t              cfg_q, cfg_d;
    logic [CLK_DIV_W-1:0] div_q, div_d;
    logic [CLK_DIV_W-1:0] baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_W-1:0]    shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [DATA_W-1:0]    fifo_dat;
    logic [LVL_W-1:0]     fifo_level;

    logic [3:0]           dbits_eff;
    logic [DATA_W-1:0]    data_mask;
    logic [DATA_W-1:0]    data_eff;
    logic [CLK_DIV_W-1:0] div_eff;
    logic                 par_req;
    logic                 bit_end;
    logic                 start_frame;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (wr_valid_i),
        .wr_dat (wr_data_i),
        .pop    (fifo_pop),
        .rd_dat (fifo_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // Control fields as they would apply to a frame launched this cycle.
    assign dbits_eff = clamp_dbits(cr_dbits_i, 4'(DATA_W));
    assign data_mask = (DATA_W'(1) << dbits_eff) - DATA_W'(1);
    assign data_eff  = fifo_dat & data_mask;
    assign div_eff   = (cr_clk_div_i == '0) ? CLK_DIV_W'(1) : cr_clk_div_i;
    assign fifo_pop  = start_frame;

    always_comb begin
        par_req = 1'b0;
        case (parity_t'(cr_p_i))
            ODD:     par_req = ~^data_eff;
            EVEN:    par_req = ^data_eff;
            STICK:   par_req = cr_pstick_i;
            default: par_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        div_d       = div_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        par_bit_d   = par_bit_q;
        done_d      = 1'b0;
        start_frame = 1'b0;
        tx_d        = 1'b1;
        bit_end     = (baud_q == '0);

        case (state_q)
            IDLE: begin
                if (cr_brk_i) begin
                    state_d = BREAK;
                end else if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
            end
            BREAK: begin
                if (!cr_brk_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                baud_d = bit_end ? (div_q - CLK_DIV_W'(1)) : (baud_q - CLK_DIV_W'(1));
                case (state_q)
                    START: begin
                        if (bit_end) begin
                            state_d = DATA;
                            bit_d   = cfg_q.dbits - 4'd1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            shreg_d = shreg_q >> 1;
                            if (bit_q == '0) begin
                                state_d = (cfg_q.par == NONE) ? STOP : PARITY;
                                bit_d   = {3'b000, cfg_q.stop2};
                            end else begin
                                bit_d = bit_q - 4'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state_d = STOP;
                            bit_d   = {3'b000, cfg_q.stop2};
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            if (bit_q == '0) begin
                                done_d = 1'b1;
                                if (!fifo_empty && !cr_brk_i) begin
                                    start_frame = 1'b1;
                                end else begin
                                    state_d = IDLE;
                                end
                            end else begin
                                bit_d = bit_q - 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        endcase

        if (start_frame) begin
            state_d     = START;
            cfg_d.dbits = dbits_eff;
            cfg_d.par   = parity_t'(cr_p_i);
            cfg_d.stop2 = cr_s_i;
            div_d       = div_eff;
            baud_d      = div_eff - CLK_DIV_W'(1);
            shreg_d     = data_eff;
            par_bit_d   = par_req;
        end

        // The line register follows the state being entered, so the pin changes on the same edge.
        case (state_d)
            START, BREAK: tx_d = 1'b0;
            DATA:         tx_d = shreg_d[0];
            PARITY:       tx_d = par_bit_d;
            default:      tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            div_q     <= CLK_DIV_W'(1);
            baud_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            div_q     <= div_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign wr_ready_o = ~fifo_full;
    assign level_o    = fifo_level;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign uart_tx_o  = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: frame shapes, parity modes, FIFO backpressure, break and reset.
module tb_uart_tx_buffered;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] cr_clk_div_i;
    logic [3:0]  cr_dbits_i;
    logic [1:0]  cr_p_i;
    logic        cr_pstick_i;
    logic        cr_s_i;
    logic        cr_brk_i;
    logic        wr_valid_i;
    logic [7:0]  wr_data_i;
    logic        wr_ready_o;
    logic [2:0]  level_o;
    logic        busy_o;
    logic        done_o;
    logic        uart_tx_o;

    int n_checks = 0;
    int n_err    = 0;

    // Frame bit vectors: bit 0 is the first bit on the line (start bit).
    logic [1:0]  par_mode [4] = '{2'b10, 2'b01, 2'b11, 2'b11};
    logic        par_stk  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] par_exp  [4] = '{16'h0606, 16'h0706, 16'h0706, 16'h0606};
    logic [7:0]  b2b_dat  [6] = '{8'hE1, 8'h1F, 8'h0A, 8'hF5, 8'h13, 8'h0C};
    logic [15:0] b2b_exp  [5] = '{16'h0042, 16'h007E, 16'h0054, 16'h006A, 16'h0066};

    uart_tx_buffered #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .CLK_DIV_W  (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cr_clk_div_i (cr_clk_div_i),
        .cr_dbits_i   (cr_dbits_i),
        .cr_p_i       (cr_p_i),
        .cr_pstick_i  (cr_pstick_i),
        .cr_s_i       (cr_s_i),
        .cr_brk_i     (cr_brk_i),
        .wr_valid_i   (wr_valid_i),
        .wr_data_i    (wr_data_i),
        .wr_ready_o   (wr_ready_o),
        .level_o      (level_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .uart_tx_o    (uart_tx_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_char(input logic [7:0] d);
        wr_valid_i = 1'b1;
        wr_data_i  = d;
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic set_cfg(input logic [15:0] div, input logic [3:0] dbits, input logic [1:0] p,
                           input logic stk, input logic s);
        cr_clk_div_i = div;
        cr_dbits_i   = dbits;
        cr_p_i       = p;
        cr_pstick_i  = stk;
        cr_s_i       = s;
    endtask

    // Called on the first START cycle; returns on the cycle after the last stop cycle.
    task automatic run_frame(input logic [15:0] exp_bits, input int nbits, input int div, input string name);
        int   len;
        int   bad;
        int   bad_idx;
        int   dones;
        logic bad_val;
        logic exp_val;
        len     = nbits * div;
        bad     = 0;
        bad_idx = -1;
        dones   = 0;
        bad_val = 1'b0;
        exp_val = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i > 0) tick();
            if (i < len && uart_tx_o !== exp_bits[i / div]) begin
                if (bad == 0) begin
                    bad_idx = i;
                    bad_val = uart_tx_o;
                    exp_val = exp_bits[i / div];
                end
                bad++;
            end
            if (i > 0 && done_o === 1'b1) dones++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL %s line: %0d wrong cycles, first at cycle %0d got %b required %b",
                     name, bad, bad_idx, bad_val, exp_val);
        end
        n_checks++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL %s done count: got %0d required 1", name, dones);
        end
        n_checks++;
        if (done_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s done position: got %b required 1 right after last stop cycle", name, done_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        n_checks++; if (uart_tx_o !== 1'b1)  begin n_err++; $display("FAIL reset tx: got %b required 1", uart_tx_o); end
        n_checks++; if (wr_ready_o !== 1'b1) begin n_err++; $display("FAIL reset wr_ready: got %b required 1", wr_ready_o); end
        n_checks++; if (level_o !== 3'd0)    begin n_err++; $display("FAIL reset level: got %0d required 0", level_o); end
        n_checks++; if (busy_o !== 1'b0)     begin n_err++; $display("FAIL reset busy: got %b required 0", busy_o); end
        n_checks++; if (done_o !== 1'b0)     begin n_err++; $display("FAIL reset done: got %b required 0", done_o); end
    endtask

    task automatic test_basic_8n1();
        set_cfg(16'd4, 4'd8, 2'b00, 1'b0, 1'b0);
        write_char(8'h55);
        n_checks++; if (level_o !== 3'd1)   begin n_err++; $display("FAIL 8n1 level after write: got %0d required 1", level_o); end
        n_checks++; if (uart_tx_o !== 1'b1) begin n_err++; $display("FAIL 8n1 tx in pop cycle: got %b required 1", uart_tx_o); end
        tick();
        n_checks++; if (level_o !== 3'd0)   begin n_err++; $display("FAIL 8n1 level after pop: got %0d required 0", level_o); end
        n_checks++; if (busy_o !== 1'b1)    begin n_err++; $display("FAIL 8n1 busy in frame: got %b required 1", busy_o); end
        run_frame(16'h02AA, 10, 4, "8n1");
        n_checks++; if (busy_o !== 1'b0)    begin n_err++; $display("FAIL 8n1 busy after frame: got %b required 0", busy_o); end
        tick();
        n_checks++; if (done_o !== 1'b0)    begin n_err++; $display("FAIL 8n1 done width: got %b required 0", done_o); end
    endtask

    task automatic test_parity();
        for (int m = 0; m < 4; m++) begin
            set_cfg(16'd2, 4'd7, par_mode[m], par_stk[m], 1'b1);
            write_char(8'h03);
            tick();
            run_frame(par_exp[m], 11, 2, $sformatf("parity%0d", m));
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int high_cnt;
        set_cfg(16'd2, 4'd5, 2'b00, 1'b0, 1'b0);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    wr_valid_i = 1'b1;
                    wr_data_i  = b2b_dat[k];
                    tick();
                end
                wr_valid_i = 1'b0;
                n_checks++; if (level_o !== 3'd4)    begin n_err++; $display("FAIL b2b level full: got %0d required 4", level_o); end
                n_checks++; if (wr_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b wr_ready full: got %b required 0", wr_ready_o); end
            end
            begin
                tick();
                tick();
                for (int k = 0; k < 5; k++) begin
                    run_frame(b2b_exp[k], 7, 2, $sformatf("b2b%0d", k));
                end
            end
        join
        n_checks++; if (busy_o !== 1'b0)  begin n_err++; $display("FAIL b2b busy after last: got %b required 0", busy_o); end
        n_checks++; if (level_o !== 3'd0) begin n_err++; $display("FAIL b2b level after last: got %0d required 0", level_o); end
        high_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (uart_tx_o === 1'b1 && busy_o === 1'b0) high_cnt++;
        end
        n_checks++; if (high_cnt !== 10) begin n_err++; $display("FAIL b2b dropped write sent: idle cycles %0d required 10", high_cnt); end
    endtask

    task automatic test_break();
        int low_cnt;
        set_cfg(16'd2, 4'd5, 2'b00, 1'b0, 1'b0);
        wr_valid_i = 1'b1;
        wr_data_i  = 8'hE1;
        tick();
        wr_data_i  = 8'h1F;
        tick();
        wr_valid_i = 1'b0;
        cr_brk_i   = 1'b1;
        run_frame(16'h0042, 7, 2, "brk_frame");
        n_checks++; if (level_o !== 3'd1) begin n_err++; $display("FAIL brk queued level: got %0d required 1", level_o); end
        low_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (uart_tx_o === 1'b0 && busy_o === 1'b1) low_cnt++;
        end
        n_checks++; if (low_cnt !== 6) begin n_err++; $display("FAIL brk line low: low cycles %0d required 6", low_cnt); end
        n_checks++; if (level_o !== 3'd1) begin n_err++; $display("FAIL brk level held: got %0d required 1", level_o); end
        cr_brk_i = 1'b0;
        tick();
        n_checks++; if (uart_tx_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL brk exit idle: got tx=%b busy=%b required tx=1 busy=0", uart_tx_o, busy_o);
        end
        tick();
        n_checks++; if (level_o !== 3'd0) begin n_err++; $display("FAIL brk queued pop: got level %0d required 0", level_o); end
        run_frame(16'h007E, 7, 2, "brk_queued");
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        set_cfg(16'd4, 4'd8, 2'b00, 1'b0, 1'b0);
        wr_valid_i = 1'b1;
        wr_data_i  = 8'hA5;
        tick();
        wr_data_i  = 8'h3C;
        tick();
        wr_valid_i = 1'b0;
        repeat (9) tick();
        n_checks++; if (uart_tx_o !== 1'b0 || level_o !== 3'd1) begin
            n_err++; $display("FAIL rst pre: got tx=%b level=%0d required tx=0 level=1", uart_tx_o, level_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_checks++; if (uart_tx_o !== 1'b1)  begin n_err++; $display("FAIL rst tx: got %b required 1", uart_tx_o); end
        n_checks++; if (level_o !== 3'd0)    begin n_err++; $display("FAIL rst level: got %0d required 0", level_o); end
        n_checks++; if (busy_o !== 1'b0)     begin n_err++; $display("FAIL rst busy: got %b required 0", busy_o); end
        n_checks++; if (wr_ready_o !== 1'b1) begin n_err++; $display("FAIL rst wr_ready: got %b required 1", wr_ready_o); end
        bad = 0;
        for (int i = 0; i < 45; i++) begin
            if (done_o !== 1'b0 || uart_tx_o !== 1'b1) bad++;
            tick();
        end
        n_checks++; if (bad !== 0) begin n_err++; $display("FAIL rst quiet: got %0d active cycles required 0", bad); end
    endtask

    task automatic test_div0_dbits_clamp();
        set_cfg(16'd0, 4'd15, 2'b00, 1'b0, 1'b0);
        write_char(8'h96);
        tick();
        run_frame(16'h032C, 10, 1, "div0");
        tick();
        n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL div0 busy after frame: got %b required 0", busy_o); end
    endtask

    initial begin
        rst_i      = 1'b1;
        cr_brk_i   = 1'b0;
        wr_valid_i = 1'b0;
        wr_data_i  = 8'h00;
        set_cfg(16'd4, 4'd8, 2'b00, 1'b0, 1'b0);
        test_reset();
        test_basic_8n1();
        test_parity();
        test_back_to_back();
        test_break();
        test_reset_mid_frame();
        test_div0_dbits_clamp();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised UART transmit engine succeeding the fixed 8-bit transmitter: accepts characters over a valid/ready write port into an internal FIFO and serialises them back-to-back onto the TX line. Adds configurable data width (5..DATA_W bits), odd/even/mark/space parity, 1 or 2 stop bits, break generation and occupancy status. It sits between the Wishbone register front end (which writes characters and drives the control fields) and the `uart_tx` pin.

## Interface
- DATA_W, 8, maximum data bits per character (5..9)
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2
- CLK_DIV_W, 16, width of baud divider
- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-high reset
- cr_clk_div_i  in  CLK_DIV_W  clock cycles per bit; 0 is treated as 1
- cr_dbits_i  in  4  data bits per character; below 5 means 5, above DATA_W means DATA_W
- cr_p_i  in  2  parity: 00 none, 01 odd, 10 even, 11 see cr_pstick_i
- cr_pstick_i  in  1  with cr_p_i=11: 0 = space (0), 1 = mark (1)
- cr_s_i  in  1  stop bits: 0 = one, 1 = two
- cr_brk_i  in  1  break request
- wr_valid_i  in  1  write character
- wr_data_i  in  DATA_W  character, LSB first; bits above active width ignored
- wr_ready_o  out  1  FIFO not full
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- busy_o  out  1  frame in progress (state != IDLE)
- done_o  out  1  one-cycle pulse at end of each frame
- uart_tx_o  out  1  serial line, registered

## Operation
- Write accepted when wr_valid_i && wr_ready_o. A write while full is dropped; the FIFO is unchanged.
- Simultaneous push and pop on a non-full FIFO: both occur and level_o is unchanged.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE → START when the FIFO is non-empty and cr_brk_i=0. This pops the head and latches the data, cr_dbits, parity mode and stop count; those fields hold for the whole frame.
- IDLE → BREAK when cr_brk_i=1. Break has priority over a non-empty FIFO.
- BREAK drives the line 0. BREAK → IDLE on the first cycle cr_brk_i=0. cr_brk_i has no effect outside IDLE/BREAK; the current frame completes first.
- START: one bit period at 0.
- DATA: the latched dbits bits, LSB first.
- PARITY: skipped if mode is none. Odd and even are computed over the active data bits only; mark sends 1, space sends 0.
- STOP: one or two bit periods at 1.
- On the last cycle of the final stop bit, done_o is pulsed the next cycle (registered).
  - If the FIFO is non-empty and cr_brk_i=0, the engine pops and enters START directly, with zero idle cycles.
  - Otherwise it enters IDLE.
- The baud counter reloads cr_clk_div-1 at every bit boundary; the divider is latched per frame.
- Frame length = (1 + dbits + P + S) × div cycles, with P in {0,1} and S in {1,2}.

## Timing
- Reset values: uart_tx_o=1, wr_ready_o=1, level_o=0, busy_o=0, done_o=0. The FIFO is emptied and the state is IDLE.
- Reset mid-frame aborts the frame. The line is 1 from the cycle after rst_i is sampled.
- Latency from a write into an empty FIFO while IDLE:
  - level_o=1 on the next cycle, and the IDLE→START pop occurs in that same cycle (level_o back to 0 the cycle after).
  - uart_tx_o falls 1 cycle after the pop cycle (registered output).
- Each bit holds uart_tx_o for exactly div cycles, with no jitter between consecutive frames.
- done_o is high for exactly one cycle per frame. It coincides with the first START cycle of a back-to-back frame.
- wr_ready_o and level_o reflect the registered FIFO state, with no combinational path from wr_valid_i.

## Structure
- Package uart_pkg:
  - parity_t (NONE, ODD, EVEN, STICK)
  - tx_state_t
  - MIN_DBITS=5
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level). It is reusable by the RX path.
- The engine FSM, baud counter, bit counter, shift register and parity accumulator live in uart_tx_buffered.

## Test plan
- div=4, dbits=8, no parity, 1 stop, write 0x55 → 40 line cycles: 0,1,0,1,0,1,0,1,0,1 each 4 cycles; one done_o pulse.
- div=2, dbits=7, even parity, 2 stops, write 0x03 → parity bit 0, frame 22 cycles. Repeat with odd → parity 1. Mark/space → constant 1/0.
- Write 5 characters back-to-back with FIFO_DEPTH=4 while idle.
  - wr_ready_o drops once the FIFO is full. After the first pop, 4 entries are held, so the 5th write is accepted only if issued after that pop; otherwise it is dropped.
  - All accepted frames are sent with zero gap; done_o fires once per frame.
- Assert cr_brk_i mid-frame → the frame completes, then the line stays 0 until deassert, then IDLE. A queued character is sent afterwards.
- Assert rst_i during DATA → next cycle uart_tx_o=1, level_o=0, busy_o=0, no done_o.
- cr_clk_div_i=0 and cr_dbits_i=15 with DATA_W=8 → 1 cycle per bit and 8 data bits sent.
